counter_run_controller: RTL and testbench

- Sequencing controller for the board-level 4-bit up counter: start/stop/pause control, a programmable terminal count, and an optional auto-reload.
- Replaces a free-running clock-divider bit used as a clock with a single-clock design. An internal prescaler produces a one-cycle tick enable, and all state advances on clk only.
- Sits between debounced push-button pulses and the LED/7-seg display of count.

---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 35 +++
 rtl/counter_run_controller.sv | 122 ++++++++++++
 tb/tb_counter_run_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the counter run controller: state encoding and
// default prescaler/counter sizing.
package counter_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DEFAULT_DIV_COUNT = 8388608;
  localparam int DEFAULT_DIV_W     = 23;
  localparam int DEFAULT_CNT_W     = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV_COUNT cycle counter producing a one-cycle tick enable on the
// cycle it wraps. clr has priority over en; shared by other board blocks.
module tick_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int DIV_COUNT = DEFAULT_DIV_COUNT,
  parameter int DIV_W     = DEFAULT_DIV_W
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0] cnt;

  // Combinational so the owner can act on the wrap in the same cycle.
  assign tick = en && !clr && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_run_controller.sv
// Start/stop/pause sequencer for the board 4-bit up counter with programmable
// terminal count and optional auto-reload; single clock, prescaled tick enable.
module counter_run_controller
  import counter_ctrl_pkg::*;
#(
  parameter int DIV_COUNT = DEFAULT_DIV_COUNT,
  parameter int DIV_W     = DEFAULT_DIV_W,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [CNT_W-1:0] target,
  input  logic             autoreload,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] target_n;
  logic [CNT_W-1:0] count_inc;
  logic [1:0]       state_n;
  logic             done_n;
  logic             tick_n;
  logic             pre_en;
  logic             pre_clr;
  logic             pre_tick;

  // Any start or stop restarts the prescaler; it only advances while running.
  assign pre_clr = stop || start;
  assign pre_en  = (state == ST_RUN) && !pre_clr;

  tick_prescaler #(
    .DIV_COUNT (DIV_COUNT),
    .DIV_W     (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (pre_tick)
  );

  assign count_inc = count + CNT_W'(1);

  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    count_n  = count;
    target_n = target_q;
    done_n   = 1'b0;
    tick_n   = 1'b0;

    if (stop) begin
      state_n = ST_IDLE;
      count_n = '0;
    end else if (start) begin
      state_n  = ST_RUN;
      count_n  = '0;
      target_n = target;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_n = ST_HOLD;
          end
          // A coincident tick still updates count; a terminal stop beats HOLD.
          if (pre_tick) begin
            tick_n = 1'b1;
            if (count_inc != target_q) begin
              count_n = count_inc;
            end else if (autoreload) begin
              count_n = '0;
              done_n  = 1'b1;
            end else begin
              count_n = target_q;
              done_n  = 1'b1;
              state_n = ST_DONE;
            end
          end
        end
        ST_HOLD: begin
          if (pause) begin
            state_n = ST_RUN;
          end
        end
        ST_DONE: begin
          done_n = done;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      target_q <= '0;
      done     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      target_q <= target_n;
      done     <= done_n;
      tick     <= tick_n;
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_HOLD);

endmodule

// File: tb/tb_counter_run_controller.sv
// Scoreboard bench for counter_run_controller: directed scenarios plus random
// pulse streams, checked against a cycle-count reference model.
module tb_counter_run_controller;

  localparam int DIV  = 4;
  localparam int CW   = 4;
  localparam int MODN = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          pause;
  logic [CW-1:0] target;
  logic          autoreload;
  logic [CW-1:0] count;
  logic          tick;
  logic          busy;
  logic          done;
  logic [1:0]    state;

  always #5 clk = ~clk;

  counter_run_controller #(
    .DIV_COUNT (DIV),
    .DIV_W     (3),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .target     (target),
    .autoreload (autoreload),
    .count      (count),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  typedef struct {
    int count;
    int tick;
    int busy;
    int done;
    int state;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode, count, latched target and cycles elapsed in RUN
  // since the last tick (or since the run began).
  int m_mode, m_count, m_target, m_elapsed, m_done, m_tick;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic sp,
                            input logic p, input int tg, input logic ar);
    int nxt;
    if (!r) begin
      m_mode = M_IDLE; m_count = 0; m_target = 0;
      m_elapsed = 0; m_done = 0; m_tick = 0;
    end else if (sp) begin
      m_mode = M_IDLE; m_count = 0; m_elapsed = 0; m_done = 0; m_tick = 0;
    end else if (s) begin
      m_mode = M_RUN; m_count = 0; m_elapsed = 0; m_done = 0; m_tick = 0;
      m_target = tg;
    end else begin
      m_tick = 0;
      if (m_mode != M_DONE) m_done = 0;
      if (m_mode == M_RUN) begin
        m_elapsed++;
        if (m_elapsed == DIV) begin
          m_elapsed = 0;
          m_tick = 1;
          nxt = (m_count + 1) % MODN;
          if (nxt != m_target) begin
            m_count = nxt;
          end else if (ar) begin
            m_count = 0;
            m_done = 1;
          end else begin
            m_count = nxt;
            m_done = 1;
            m_mode = M_DONE;
          end
        end
        if (p && m_mode == M_RUN) m_mode = M_HOLD;
      end else if (m_mode == M_HOLD && p) begin
        m_mode = M_RUN;
      end
    end
  endtask

  // One clock cycle of stimulus: drive on the falling edge, predict, enqueue.
  task automatic drive(input logic r, input logic s, input logic sp,
                       input logic p, input logic [CW-1:0] tg, input logic ar);
    exp_t e;
    @(negedge clk);
    rst_n = r; start = s; stop = sp; pause = p; target = tg; autoreload = ar;
    model_step(r, s, sp, p, int'(tg), ar);
    e.count = m_count;
    e.tick  = m_tick;
    e.busy  = (m_mode == M_RUN || m_mode == M_HOLD) ? 1 : 0;
    e.done  = m_done;
    e.state = m_mode;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [CW-1:0] tg, input logic ar);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, tg, ar);
  endtask

  // Advance until the model reaches the requested condition, bounded.
  task automatic idle_until_count(input int c, input logic [CW-1:0] tg,
                                  input logic ar, input string name);
    int g = 0;
    while (!(m_count == c && m_mode == M_RUN && m_elapsed == 0) && g < 200) begin
      idle(1, tg, ar);
      g++;
    end
    if (g >= 200) check(name, g, 0);
  endtask

  task automatic idle_until_phase(input int ph, input logic [CW-1:0] tg,
                                  input logic ar, input string name);
    int g = 0;
    while (!(m_elapsed == ph && m_mode == M_RUN) && g < 200) begin
      idle(1, tg, ar);
      g++;
    end
    if (g >= 200) check(name, g, 0);
  endtask

  // Monitor: compare every registered output just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("count", int'(count), e.count);
      check("tick",  int'(tick),  e.tick);
      check("busy",  int'(busy),  e.busy);
      check("done",  int'(done),  e.done);
      check("state", int'(state), e.state);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    target = '0; autoreload = 1'b0;

    // 1: reset held with start pulsed, then quiet after release.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0);
    idle(6, 4'd7, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
    idle(3, 4'd7, 1'b0);

    // 2: target 5, no reload: DONE after 20 cycles, then holds.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
    idle(20, 4'd9, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1);
    idle(50, 4'd9, 1'b1);

    // 3: target 3 with reload: 1,2,0 repeating with done pulses.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    idle(26, 4'd3, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);

    // 4: target 0: full 16-tick wrap ends in DONE with count 0, then restart.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(16 * DIV + 6, 4'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(3, 4'd0, 1'b0);

    // 5: pause at count 2, resume from frozen remainder, pause on a tick cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0);
    idle_until_count(2, 4'd9, 1'b0, "timeout_count2");
    idle(1, 4'd9, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    idle(40, 4'd9, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    idle_until_phase(DIV - 1, 4'd9, 1'b0, "timeout_phase");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    idle(12, 4'd9, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    idle(6, 4'd9, 1'b0);

    // 6: start+stop together -> IDLE; then async reset mid-prescale.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
    idle(3, 4'd9, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
    idle(2 * DIV + 2, 4'd2, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_count", int'(count), 0);
    check("async_tick",  int'(tick),  0);
    check("async_busy",  int'(busy),  0);
    check("async_done",  int'(done),  0);
    check("async_state", int'(state), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
    idle(3, 4'd2, 1'b1);

    // Random pulse streams with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic r, s, sp, p, ar;
      logic [CW-1:0] tg;
      r  = ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 69) == 0);
      p  = ($urandom_range(0, 19) == 0);
      ar = 1'(($urandom_range(0, 1)));
      tg = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 4))
                                        : CW'($urandom_range(0, 15));
      drive(r, s, sp, p, tg, ar);
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
